// File: rtl/alu_mult_seq.sv
// Multi-cycle unsigned 32x32->64 multiply that borrows the execute-stage ALU for shift-add steps.
// Latency: 33 cycles from the accepting start edge to the one-cycle done pulse.
// Backpressure: none; busy stalls the pipeline while RUN, and a start during RUN is ignored.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   start_e, src_AE, src_BE        start request and operands (multiplicand, multiplier)
//   flush_e                        aborts a running op; blocks a same-cycle start
//   alu_grant, alu_src_a/b,        request for the shared ALU (zeros when not granted)
//   alu_control_m, alu_result      and its combinational ADDU result
//   busy, done, hi_out, lo_out     status and the 64-bit product
module alu_mult_seq #(
  parameter int         WIDTH     = 32,
  parameter logic [4:0] ADDU_CODE = 5'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_e,
  input  logic [WIDTH-1:0] src_AE,
  input  logic [WIDTH-1:0] src_BE,
  input  logic             flush_e,
  output logic             alu_grant,
  output logic [WIDTH-1:0] alu_src_a,
  output logic [WIDTH-1:0] alu_src_b,
  output logic [4:0]       alu_control_m,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] hi, hi_nxt;
  logic [WIDTH-1:0] lo, lo_nxt;
  logic [WIDTH-1:0] mcand, mcand_nxt;
  logic [4:0]       cnt, cnt_nxt;
  logic             carry;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      mcand <= mcand_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The ALU adds modulo 2^WIDTH; an unsigned wrap below operand A means the
  // addition carried out, and that bit becomes the new MSB of hi after the shift.
  assign carry = (alu_result < hi);

  always_comb begin
    state_nxt = state;
    hi_nxt    = hi;
    lo_nxt    = lo;
    mcand_nxt = mcand;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE, ST_DONE: begin
        // A flushed instruction must never launch, so flush_e masks start_e.
        if (start_e && !flush_e) begin
          state_nxt = ST_RUN;
          hi_nxt    = '0;
          lo_nxt    = src_BE;
          mcand_nxt = src_AE;
          cnt_nxt   = '0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (flush_e) begin
          // Abort without applying this cycle's step; hi/lo keep partial values.
          state_nxt = ST_IDLE;
        end else begin
          hi_nxt  = {carry, alu_result[WIDTH-1:1]};
          lo_nxt  = {alu_result[0], lo[WIDTH-1:1]};
          cnt_nxt = cnt + 5'd1;
          if (cnt == 5'd31) begin
            state_nxt = ST_DONE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs decode registered state only; nothing here looks at alu_result.
  always_comb begin
    busy          = (state == ST_RUN);
    alu_grant     = (state == ST_RUN);
    done          = (state == ST_DONE);
    alu_src_a     = '0;
    alu_src_b     = '0;
    alu_control_m = '0;
    if (state == ST_RUN) begin
      alu_src_a     = hi;
      alu_src_b     = lo[0] ? mcand : '0;
      alu_control_m = ADDU_CODE;
    end
  end

  assign hi_out = hi;
  assign lo_out = lo;

endmodule

// File: doc/alu_mult_seq.md
# alu_mult_seq

Multi-cycle unsigned multiply sequencer (MULTU) for the execute stage. It borrows the shared ALU in execute and drives ADDU operations on it, one per cycle for 32 cycles. It builds a 64-bit product in internal HI/LO registers using shift-add. While it owns the ALU it asserts `busy`, and the hazard logic uses this to stall the pipeline.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. Only 32 is supported.
- `ADDU_CODE`, default 1: ALU control code for ADDU. It must match the ALU op encoding.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start_e` input 1: start request. Operands are sampled on the same edge.
- `src_AE` input 32: multiplicand.
- `src_BE` input 32: multiplier.
- `flush_e` input 1: abort the operation in progress (branch/exception flush).
- `alu_grant` output 1: when high, the execute-stage ALU input mux selects this block's operands and control.
- `alu_src_a` output 32: ALU operand A.
- `alu_src_b` output 32: ALU operand B.
- `alu_control_m` output 5: ALU op code.
- `alu_result` input 32: ALU output. The ALU is combinational, so the result returns in the same cycle.
- `busy` output 1: sequencer is running. The pipeline must stall.
- `done` output 1: one-cycle pulse when the product is valid.
- `hi_out` output 32: upper half of the product.
- `lo_out` output 32: lower half of the product.

## Operation
- States:
  - IDLE: waiting for a start.
  - RUN: iterating. A 5-bit counter `cnt` runs 0..31.
  - DONE: one cycle.
- IDLE → RUN on `start_e`:
  - hi ← 0, lo ← `src_BE`, mcand ← `src_AE`, cnt ← 0.
- Each RUN cycle:
  - `alu_grant`=1 and `alu_control_m`=`ADDU_CODE`.
  - `alu_src_a` = hi.
  - `alu_src_b` = lo[0] ? mcand : 0.
  - carry = (`alu_result` < `alu_src_a`), compared unsigned.
  - Register update: hi ← {carry, `alu_result`[31:1]}, lo ← {`alu_result`[0], lo[31:1]}, cnt ← cnt+1.
- RUN → DONE after the cnt==31 iteration.
- DONE: `done`=1 for one cycle, then go to IDLE.
  - A `start_e` in the DONE cycle is accepted and goes straight to RUN with new operands.
- When `alu_grant`=0: `alu_src_a`, `alu_src_b` and `alu_control_m` drive 0.
- `hi_out`/`lo_out`:
  - Always show hi/lo.
  - Meaningful from the `done` cycle until the next accepted start.
  - They hold their value in IDLE.
- `start_e` while in RUN: ignored. The operation continues and the operands are not resampled.
- `flush_e` in RUN:
  - Next state is IDLE.
  - hi/lo keep their partial values.
  - No `done` pulse.
  - `flush_e` has priority over the cnt==31 transition.
- `flush_e` in IDLE or DONE:
  - No effect on state.
  - It does suppress a same-cycle `start_e`, because the flushed instruction must not launch.
- `rst_n`=0, synchronous, also mid-operation: next state is IDLE.
  - hi, lo, mcand and cnt return to 0.
  - All outputs return to 0.
- Arithmetic is modulo 2^32 per ALU op. The carry recovery makes the 64-bit result exact for all operand pairs.

## Timing
- Cycle 0: edge with `start_e`=1 in IDLE or DONE; operands captured.
- Cycles 1–32: RUN, with `busy`=1 and `alu_grant`=1 in each.
- Cycle 33: DONE, with `done`=1 and `busy`=0; `hi_out`/`lo_out` hold the final product.
- Latency from the start edge to `done` is 33 cycles.
- Back-to-back throughput is one product per 33 cycles.
- `busy`, `alu_grant` and `done` are registered state decodes, glitch-free with respect to inputs.
- The only input-to-output combinational path is `alu_result` feeding the next-state logic. No output depends combinationally on `alu_result`.
- Reset values: `busy`=0, `done`=0, `alu_grant`=0, `alu_src_a`=0, `alu_src_b`=0, `alu_control_m`=0, `hi_out`=0, `lo_out`=0.

## Test plan
- 3 × 5: start with `src_AE`=3, `src_BE`=5 → `done` in cycle 33 with hi=0x00000000, lo=0x0000000F; `busy` high exactly cycles 1–32.
- Max × max: 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 (checks carry recovery).
- Zero and single-bit: 0 × 0x12345678 → hi=lo=0. Separately, 0x80000000 × 2 → hi=1, lo=0.
- Ignored start: second `start_e` with new operands at cycle 10 → result still the first product; `done` only at cycle 33.
- Back-to-back start: new `start_e` in the DONE cycle → second `done` 33 cycles later with the correct second product.
- Flush mid-run: `flush_e` at cycle 15 → IDLE at cycle 16, no `done`, `alu_grant`=0.
- Reset mid-run: `rst_n`=0 at cycle 20 → after that edge all outputs 0, state IDLE; a subsequent 7 × 6 gives lo=42.
